// File: rtl/pkt_meta_sink.sv
// Pairs each egress packet with its ALU metadata, dropping or forwarding with rebuilt tuser.
// Optional drop counter: define PKT_META_SINK_DROP_CNT_EN.
module pkt_meta_sink #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int META_LEN             = 256,
  parameter int COMP_LEN             = 100,
  parameter int MD_FIFO_AW           = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [META_LEN+COMP_LEN-1:0]         comp_meta_data_in,
  input  logic                                 comp_meta_data_valid_in,
  output logic                                 comp_meta_data_ready_out,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
  input  logic                                 s_axis_tvalid,
  input  logic                                 s_axis_tlast,
  output logic                                 s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
  output logic                                 m_axis_tvalid,
  output logic                                 m_axis_tlast,
  input  logic                                 m_axis_tready,
  output logic [31:0]                          drop_cnt
);

  localparam int MW    = META_LEN + COMP_LEN;
  localparam int TW    = C_S_AXIS_TUSER_WIDTH;
  localparam int DW    = C_S_AXIS_DATA_WIDTH;
  localparam int KW    = DW / 8;
  localparam int DEPTH = 1 << MD_FIFO_AW;

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t state_q, state_d;

  logic [TW:0]           mem_q [DEPTH];
  logic [MD_FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [MD_FIFO_AW:0]   cnt_q, cnt_d;

  logic [TW:0] head;
  logic        head_drop, full, empty;
  logic        push, pop, acc, out_rdy;
  logic        s_rdy, fwd;

  logic [DW-1:0] tdata_q;
  logic [KW-1:0] tkeep_q;
  logic [TW-1:0] tuser_q;
  logic          tvalid_q, tlast_q;

  logic unused_bits;
  assign unused_bits = ^{s_axis_tuser, comp_meta_data_in[MW-1:TW+1]};

  assign head      = mem_q[rd_ptr_q];
  assign head_drop = head[TW];
  assign full      = cnt_q == (MD_FIFO_AW+1)'(DEPTH);
  assign empty     = cnt_q == '0;
  assign out_rdy   = m_axis_tready || !tvalid_q;
  assign acc       = s_axis_tvalid && s_rdy;
  assign pop       = acc && s_axis_tlast;
  // A pop frees the slot being written, so a push is legal even when full.
  assign push      = comp_meta_data_valid_in && (!full || pop);

  assign comp_meta_data_ready_out = !full;
  assign s_axis_tready            = s_rdy;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= comp_meta_data_in[TW:0];
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (acc && !s_axis_tlast) state_d = head_drop ? DROP : FWD;
      FWD:  if (pop) state_d = IDLE;
      DROP: if (pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_rdy = 1'b0;
    fwd   = 1'b0;
    unique case (state_q)
      IDLE: begin
        s_rdy = !empty && (head_drop || out_rdy);
        fwd   = !head_drop;
      end
      FWD: begin
        s_rdy = out_rdy;
        fwd   = 1'b1;
      end
      DROP: s_rdy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tuser_q  <= '0;
      tlast_q  <= 1'b0;
    end else if (acc && fwd) begin
      tvalid_q <= 1'b1;
      tdata_q  <= s_axis_tdata;
      tkeep_q  <= s_axis_tkeep;
      tuser_q  <= (state_q == IDLE) ? head[TW-1:0] : '0;
      tlast_q  <= s_axis_tlast;
    end else if (m_axis_tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;

`ifdef PKT_META_SINK_DROP_CNT_EN
  logic [31:0] drop_cnt_q;
  logic        drop_done;
  assign drop_done = pop && !fwd;

  always_ff @(posedge clk) begin
    if (rst)            drop_cnt_q <= '0;
    else if (drop_done) drop_cnt_q <= drop_cnt_q + 32'd1;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_meta_sink.sv
// Scoreboard bench for pkt_meta_sink: metadata and beats modelled in queues,
// output beats popped and compared as the DUT hands them off.
module tb_pkt_meta_sink;

  localparam int DW = 256;
  localparam int KW = 32;
  localparam int TW = 128;
  localparam int MW = 356;

  typedef logic [DW+KW+TW:0] beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [MW-1:0] md_in = '0;
  logic          md_valid = 1'b0;
  logic          md_ready;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic [TW-1:0] s_tuser = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [TW-1:0] m_tuser;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready = 1'b1;
  logic [31:0]   drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_drops = 0;

  beat_t       exp_q[$];
  logic [TW:0] meta_q[$];

  pkt_meta_sink dut (
    .clk(clk), .rst(rst),
    .comp_meta_data_in(md_in),
    .comp_meta_data_valid_in(md_valid),
    .comp_meta_data_ready_out(md_ready),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
    .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
    .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_drop_cnt();
`ifdef PKT_META_SINK_DROP_CNT_EN
    return 32'(exp_drops);
`else
    return 32'd0;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      beat_t got, want;
      got = {m_tdata, m_tkeep, m_tuser, m_tlast};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected got %h want none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL out_beat got %h want %h", got, want);
        end
      end
    end
  end

  task automatic push_meta(input logic disc, input logic [7:0] port);
    logic [MW-1:0] v;
    int guard = 0;
    for (int i = 0; i < MW; i += 32) v[i +: 4] = 4'($urandom);
    for (int i = 0; i < MW; i++) v[i] = 1'($urandom);
    v[TW] = disc;
    v[31:24] = port;
    md_in = v;
    md_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (md_ready) begin
        meta_q.push_back(v[TW:0]);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      if (++guard > 100) begin
        n_tests++; n_fail++;
        $display("FAIL meta_push_timeout got ready=0 want 1");
        break;
      end
    end
    md_valid = 1'b0;
  endtask

  task automatic send_pkt(input int nb, input logic [7:0] tag,
                          input bit trunc, output int stalls);
    logic [TW:0] md;
    bit acc;
    int guard;
    stalls = 0;
    md = '0;
    for (int b = 0; b < nb; b++) begin
      s_tdata  = {8{tag, 24'(b)}};
      s_tkeep  = (b == nb - 1) ? 32'h0000_ffff : '1;
      s_tuser  = {4{$urandom}};
      s_tlast  = (b == nb - 1) && !trunc;
      s_tvalid = 1'b1;
      acc = 1'b0;
      guard = 0;
      while (!acc) begin
        @(negedge clk);
        acc = s_tready;
        if (acc) begin
          if (b == 0) begin
            if (meta_q.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL accept_no_meta got accept want stall");
            end else md = meta_q[0];
          end
          if (!md[TW])
            exp_q.push_back({s_tdata, s_tkeep,
                             (b == 0) ? md[TW-1:0] : {TW{1'b0}}, s_tlast});
          if (s_tlast) begin
            if (meta_q.size() != 0) void'(meta_q.pop_front());
            if (md[TW]) exp_drops++;
          end
        end else stalls++;
        @(posedge clk); #1;
        if (!acc && ++guard > 100) begin
          n_tests++; n_fail++;
          $display("FAIL beat_timeout got tready=0 want 1");
          s_tvalid = 1'b0;
          return;
        end
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({m_tvalid, m_tlast, m_tdata, m_tkeep, m_tuser} !== '0) begin
      n_fail++;
      $display("FAIL reset_out got v=%b d=%h u=%h want 0", m_tvalid, m_tdata, m_tuser);
    end
    n_tests++;
    if ({md_ready, s_tready} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_ready got md=%b s=%b want 1 0", md_ready, s_tready);
    end
    n_tests++;
    if (drop_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fwd();
    int st;
    push_meta(1'b0, 8'h04);
    send_pkt(3, 8'hA1, 1'b0, st);
    n_tests++;
    if (st !== 0) begin
      n_fail++;
      $display("FAIL fwd_stalls got %0d want 0", st);
    end
    n_tests++;
    if ({m_tvalid, m_tlast} !== 2'b11) begin
      n_fail++;
      $display("FAIL fwd_latency got v=%b l=%b want 1 1", m_tvalid, m_tlast);
    end
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_drop();
    int st;
    push_meta(1'b1, 8'h02);
    n_tests++;
    if (drop_cnt !== exp_drop_cnt()) begin
      n_fail++;
      $display("FAIL drop_cnt_before got %0d want %0d", drop_cnt, exp_drop_cnt());
    end
    send_pkt(4, 8'hD0, 1'b0, st);
    n_tests++;
    if (st !== 0) begin
      n_fail++;
      $display("FAIL drop_stalls got %0d want 0", st);
    end
    n_tests++;
    if (drop_cnt !== exp_drop_cnt()) begin
      n_fail++;
      $display("FAIL drop_cnt_after got %0d want %0d", drop_cnt, exp_drop_cnt());
    end
    s_tvalid = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({s_tready, md_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL drop_fifo_empty got s=%b md=%b want 0 1", s_tready, md_ready);
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_empty_fifo();
    int st;
    bit bad = 1'b0;
    fork
      send_pkt(2, 8'hE5, 1'b0, st);
      begin
        repeat (5) begin
          @(negedge clk);
          if (s_tready !== 1'b0) bad = 1'b1;
        end
        @(posedge clk); #1;
        push_meta(1'b0, 8'h07);
      end
    join
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL empty_tready got 1 want 0");
    end
    n_tests++;
    if (st < 5) begin
      n_fail++;
      $display("FAIL empty_stalls got %0d want >=5", st);
    end
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_full();
    int st;
    logic [MW-1:0] v;
    for (int i = 0; i < 4; i++) push_meta(1'b0, 8'(8'h10 + i));
    n_tests++;
    if (md_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready got %b want 0", md_ready);
    end
    send_pkt(1, 8'hF0, 1'b0, st);
    n_tests++;
    if (md_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_ready_back got %b want 1", md_ready);
    end
    push_meta(1'b0, 8'h20);
    for (int i = 0; i < MW; i++) v[i] = 1'($urandom);
    v[TW] = 1'b0;
    v[31:24] = 8'h21;
    md_in = v;
    md_valid = 1'b1;
    send_pkt(1, 8'hF1, 1'b0, st);
    md_valid = 1'b0;
    meta_q.push_back(v[TW:0]);
    n_tests++;
    if (md_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_push_pop got ready=%b want 0", md_ready);
    end
    for (int i = 0; i < 4; i++) send_pkt(1, 8'(8'hF2 + i), 1'b0, st);
    n_tests++;
    if (md_ready !== 1'b1 || meta_q.size() != 0) begin
      n_fail++;
      $display("FAIL full_drain got ready=%b left=%0d want 1 0", md_ready, meta_q.size());
    end
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int st;
    logic [DW+KW+TW+1:0] snap;
    bit bad = 1'b0;
    push_meta(1'b0, 8'h05);
    fork
      send_pkt(6, 8'hB7, 1'b0, st);
      begin
        repeat (2) @(posedge clk);
        #1 m_tready = 1'b0;
        @(negedge clk);
        snap = {m_tvalid, m_tdata, m_tkeep, m_tuser, m_tlast};
        if (!m_tvalid || s_tready) bad = 1'b1;
        repeat (4) begin
          @(negedge clk);
          if ({m_tvalid, m_tdata, m_tkeep, m_tuser, m_tlast} !== snap) bad = 1'b1;
          if (s_tready !== 1'b0) bad = 1'b1;
        end
        @(posedge clk);
        #1 m_tready = 1'b1;
      end
    join
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL bp_hold got unstable want stable");
    end
    n_tests++;
    if (st < 5) begin
      n_fail++;
      $display("FAIL bp_stalls got %0d want >=5", st);
    end
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int st, tot;
    push_meta(1'b0, 8'h31);
    push_meta(1'b1, 8'h32);
    push_meta(1'b0, 8'h33);
    tot = 0;
    send_pkt(2, 8'hC1, 1'b0, st); tot += st;
    send_pkt(3, 8'hC2, 1'b0, st); tot += st;
    send_pkt(1, 8'hC3, 1'b0, st); tot += st;
    n_tests++;
    if (tot !== 0) begin
      n_fail++;
      $display("FAIL b2b_stalls got %0d want 0", tot);
    end
    n_tests++;
    if (drop_cnt !== exp_drop_cnt()) begin
      n_fail++;
      $display("FAIL b2b_drop_cnt got %0d want %0d", drop_cnt, exp_drop_cnt());
    end
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_midreset();
    int st;
    push_meta(1'b0, 8'h09);
    send_pkt(2, 8'h9A, 1'b1, st);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    meta_q.delete();
    exp_drops = 0;
    n_tests++;
    if ({m_tvalid, s_tready, md_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL midrst_state got v=%b s=%b md=%b want 0 0 1", m_tvalid, s_tready, md_ready);
    end
    n_tests++;
    if (drop_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_drop_cnt got %0d want 0", drop_cnt);
    end
    rst = 1'b0;
    push_meta(1'b0, 8'h0B);
    send_pkt(2, 8'h9B, 1'b0, st);
    repeat (3) @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_fwd();
    test_drop();
    test_empty_fifo();
    test_full();
    test_backpressure();
    test_back_to_back();
    test_midreset();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_beats got %0d want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
